// File: rtl/stochastic_search_sequencer.sv
// stochastic_search_sequencer: loads clause slots, then runs bounded walk
// iterations (EVAL, CHECK, WAIT_LOCAL, BEST, COMMIT) until the formula is
// satisfied or the iteration budget is used up.
// Optional feature macro: STOCH_SEQ_TIMEOUT_EN (WAIT_LOCAL watchdog).
module stochastic_search_sequencer #(
  parameter int MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX = 2,
  parameter int ITERATION_COUNT_WIDTH              = 8,
  parameter int TIMEOUT_COUNT_WIDTH                = 6
) (
  input  logic                                             in_clk,
  input  logic                                             in_reset_n,
  input  logic                                             in_start,
  input  logic [ITERATION_COUNT_WIDTH-1:0]                 in_max_iterations,
  input  logic [(1<<MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX)-1:0] in_existing_clauses,
  input  logic                                             in_all_satisfied,
  input  logic                                             in_local_done,
  output logic [MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX-1:0]    out_clause_index,
  output logic                                             out_clause_load,
  output logic [(1<<MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX)-1:0] out_clauses_enable,
  output logic                                             out_find_best_gain_enable,
  output logic                                             out_commit,
  output logic                                             out_busy,
  output logic                                             out_done,
  output logic                                             out_solved,
  output logic [ITERATION_COUNT_WIDTH-1:0]                 out_iterations,
  output logic                                             out_timeout
);
  localparam int W = MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX;
  localparam int N = 1 << W;
  localparam logic [W-1:0] IDX_LAST = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_EVAL, S_CHECK, S_WAIT_LOCAL, S_BEST, S_COMMIT, S_DONE
  } state_t;

  state_t                           state;
  logic [N-1:0]                     mask;
  logic [ITERATION_COUNT_WIDTH-1:0] budget;
  logic [W-1:0]                     idx_nxt;

  assign idx_nxt = out_clause_index + 1'b1;

`ifdef STOCH_SEQ_TIMEOUT_EN
  // Last count value still inside the window; the cycle spent at this value
  // is the (2**TIMEOUT_COUNT_WIDTH-1)-th WAIT_LOCAL cycle.
  localparam logic [TIMEOUT_COUNT_WIDTH-1:0] WD_LAST =
    {{(TIMEOUT_COUNT_WIDTH-1){1'b1}}, 1'b0};
  logic [TIMEOUT_COUNT_WIDTH-1:0] wd;
`else
  // Constant 0: the watchdog width only matters when the watchdog is built.
  assign out_timeout = (TIMEOUT_COUNT_WIDTH < 0);
`endif

  // Sequencer FSM; every output is registered alongside the state it belongs to.
  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state                     <= S_IDLE;
      mask                      <= '0;
      budget                    <= '0;
      out_clause_index          <= '0;
      out_clause_load           <= 1'b0;
      out_clauses_enable        <= '0;
      out_find_best_gain_enable <= 1'b0;
      out_commit                <= 1'b0;
      out_busy                  <= 1'b0;
      out_done                  <= 1'b0;
      out_solved                <= 1'b0;
      out_iterations            <= '0;
`ifdef STOCH_SEQ_TIMEOUT_EN
      wd                        <= '0;
      out_timeout               <= 1'b0;
`endif
    end else begin
      // single-cycle strobes default low
      out_clause_load           <= 1'b0;
      out_find_best_gain_enable <= 1'b0;
      out_commit                <= 1'b0;
      out_done                  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_start) begin
            mask             <= in_existing_clauses;
            budget           <= in_max_iterations;
            out_iterations   <= '0;
            out_solved       <= 1'b0;
`ifdef STOCH_SEQ_TIMEOUT_EN
            out_timeout      <= 1'b0;
`endif
            out_clause_index <= '0;
            out_clause_load  <= in_existing_clauses[0];
            out_busy         <= 1'b1;
            state            <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (out_clause_index == IDX_LAST) begin
            out_clauses_enable <= mask;
            state              <= S_EVAL;
          end else begin
            out_clause_index <= idx_nxt;
            out_clause_load  <= mask[idx_nxt];
          end
        end
        S_EVAL: begin
          // An empty formula is trivially satisfied; it leaves here rather
          // than going through CHECK.
          if (mask == '0) begin
            out_clauses_enable <= '0;
            out_solved         <= 1'b1;
            out_done           <= 1'b1;
            state              <= S_DONE;
          end else begin
            state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (in_all_satisfied || (out_iterations == budget)) begin
            out_clauses_enable <= '0;
            out_solved         <= in_all_satisfied;
            out_done           <= 1'b1;
            state              <= S_DONE;
          end else begin
`ifdef STOCH_SEQ_TIMEOUT_EN
            wd <= '0;
`endif
            state <= S_WAIT_LOCAL;
          end
        end
        S_WAIT_LOCAL: begin
          if (in_local_done) begin
            out_clauses_enable        <= '0;
            out_find_best_gain_enable <= 1'b1;
            state                     <= S_BEST;
          end
`ifdef STOCH_SEQ_TIMEOUT_EN
          else if (wd == WD_LAST) begin
            out_clauses_enable <= '0;
            out_timeout        <= 1'b1;
            out_solved         <= 1'b0;
            out_done           <= 1'b1;
            state              <= S_DONE;
          end else begin
            wd <= wd + 1'b1;
          end
`endif
        end
        S_BEST: begin
          out_commit <= 1'b1;
          state      <= S_COMMIT;
        end
        S_COMMIT: begin
          if (out_iterations != '1) out_iterations <= out_iterations + 1'b1;
          out_clauses_enable <= mask;
          state              <= S_EVAL;
        end
        S_DONE: begin
          out_busy <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_stochastic_search_sequencer.sv
// Scoreboard bench: each run pushes its expected result, computed from the
// iteration rules, and a monitor compares on out_done and on each load strobe.
module tb_stochastic_search_sequencer;
  localparam int W   = 2;
  localparam int N   = 1 << W;
  localparam int IW  = 8;
  localparam int TW  = 6;
  localparam int TMO = (1 << TW) - 1;

  logic          in_clk = 1'b0, in_reset_n = 1'b0, in_start = 1'b0;
  logic          in_all_satisfied = 1'b0, in_local_done = 1'b0;
  logic [IW-1:0] in_max_iterations = '0;
  logic [N-1:0]  in_existing_clauses = '0;
  logic [W-1:0]  out_clause_index;
  logic          out_clause_load, out_find_best_gain_enable, out_commit;
  logic [N-1:0]  out_clauses_enable;
  logic          out_busy, out_done, out_solved, out_timeout;
  logic [IW-1:0] out_iterations;

  stochastic_search_sequencer #(
    .MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX(W),
    .ITERATION_COUNT_WIDTH(IW),
    .TIMEOUT_COUNT_WIDTH(TW)
  ) dut (
    .in_clk(in_clk), .in_reset_n(in_reset_n), .in_start(in_start),
    .in_max_iterations(in_max_iterations), .in_existing_clauses(in_existing_clauses),
    .in_all_satisfied(in_all_satisfied), .in_local_done(in_local_done),
    .out_clause_index(out_clause_index), .out_clause_load(out_clause_load),
    .out_clauses_enable(out_clauses_enable),
    .out_find_best_gain_enable(out_find_best_gain_enable), .out_commit(out_commit),
    .out_busy(out_busy), .out_done(out_done), .out_solved(out_solved),
    .out_iterations(out_iterations), .out_timeout(out_timeout)
  );

  always #5 in_clk = ~in_clk;

  typedef struct {
    int solved; int iters; int tmo; int lat; int ens;
  } exp_t;

  exp_t exp_q[$];
  int   load_q[$];
  int   checks = 0, failures = 0, cyc = 0, start_cyc = 0;
  int   commits = 0, bests = 0, ens_seen = 0, sat_at = 0;
  int   last_solved = -1;
  bit   mon_en = 1'b0;
  logic [N-1:0] cur_mask = '0;

  always @(posedge in_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, expv);
    end
  endtask

  function automatic longint all_outs();
    return longint'({out_clause_index, out_clause_load, out_clauses_enable,
                     out_find_best_gain_enable, out_commit, out_busy, out_done,
                     out_solved, out_iterations, out_timeout});
  endfunction

  // Monitor: counts strobes, plays the clause checker, pops expectations.
  initial forever begin
    @(negedge in_clk);
    if (out_commit) commits++;
    if (out_find_best_gain_enable) bests++;
    in_all_satisfied = (commits >= sat_at);
    if (mon_en) begin
      if (out_clauses_enable != '0) begin
        ens_seen++;
        chk("enables", out_clauses_enable, cur_mask);
      end
      if (out_clause_load) begin
        if (load_q.size() == 0) chk("unexpected_load", out_clause_index, -1);
        else chk("load_index", out_clause_index, load_q.pop_front());
      end
      if (out_done) begin
        if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("solved", out_solved, e.solved);
          chk("iterations", out_iterations, e.iters);
          chk("timeout", out_timeout, e.tmo);
          chk("commit_count", commits, e.iters);
          chk("best_count", bests, e.iters);
          chk("busy_in_done", out_busy, 1);
          chk("loads_missing", load_q.size(), 0);
          if (e.lat >= 0) chk("done_latency", cyc - start_cyc, e.lat);
          if (e.ens >= 0) chk("enable_cycles", ens_seen, e.ens);
          last_solved = e.solved;
        end
      end
    end
  end

  task automatic finish_now();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  // One sequencer run. sat: commits after which the checker reports satisfied.
  task automatic run(input logic [N-1:0] mask, input int budget, input int sat,
                     input bit const_ld, input bit tmo_mode);
    exp_t e;
    int   it;
    bit   seen;
    @(negedge in_clk);
    chk("idle_busy", out_busy, 0);
    if (last_solved >= 0) chk("solved_hold", out_solved, last_solved);
    commits = 0; bests = 0; ens_seen = 0; sat_at = sat; cur_mask = mask;
    in_existing_clauses = mask;
    in_max_iterations   = IW'(budget);
    in_local_done       = !tmo_mode;
    for (int i = 0; i < N; i++) if (mask[i]) load_q.push_back(i);
    if (tmo_mode) begin
      e = '{solved: 0, iters: 0, tmo: 1, lat: N + 3 + TMO, ens: 2 + TMO};
    end else begin
      it = (mask == '0) ? 0 : ((sat < budget) ? sat : budget);
      e.solved = (mask == '0 || sat <= budget) ? 1 : 0;
      e.iters  = it;
      e.tmo    = 0;
      e.lat    = const_ld ? ((mask == '0) ? N + 2 : N + 3 + 5 * it) : -1;
      e.ens    = const_ld ? ((mask == '0) ? 0 : 3 * it + 2) : -1;
    end
    exp_q.push_back(e);
    in_start  = 1'b1;
    start_cyc = cyc;
    seen = 1'b0;
    for (int c = 0; c < 2000 && !seen; c++) begin
      @(negedge in_clk);
      if (out_done) seen = 1'b1;
      else begin
        in_start = ($urandom_range(0, 1) == 1);   // must be ignored while busy
        if (!const_ld && !tmo_mode) in_local_done = ($urandom_range(0, 2) == 0);
      end
    end
    in_start = 1'b0;
    if (!seen) begin
      failures++;
      $display("FAIL run_hang actual=no_done required=done mask=%b budget=%0d", mask, budget);
      finish_now();
    end
  endtask

  initial begin
    // reset state
    #1 chk("reset_outputs", all_outs(), 0);
    repeat (3) @(negedge in_clk);
    in_reset_n = 1'b1;
    @(negedge in_clk);
    chk("idle_outputs", all_outs(), 0);

    // asynchronous reset in the middle of LOAD
    in_existing_clauses = 4'b1111; in_max_iterations = 8'd2; in_start = 1'b1;
    @(negedge in_clk); in_start = 1'b0;
    @(negedge in_clk);
    chk("mid_load_busy", out_busy, 1);
    #2 in_reset_n = 1'b0;
    #1 chk("async_reset_outputs", all_outs(), 0);
    @(negedge in_clk); in_reset_n = 1'b1;
    @(negedge in_clk);
    chk("post_reset_idle", all_outs(), 0);

    mon_en = 1'b1;
    // directed cases
    run(4'b1011, 3, 99, 1'b1, 1'b0);  // three full iterations, unsolved
    run(4'b1011, 5, 0,  1'b1, 1'b0);  // satisfied on first CHECK
    run(4'b0000, 2, 99, 1'b1, 1'b0);  // empty formula
    run(4'b1111, 0, 99, 1'b1, 1'b0);  // zero budget, unsolved
    run(4'b0100, 4, 2,  1'b1, 1'b0);  // satisfied after two commits
`ifdef STOCH_SEQ_TIMEOUT_EN
    run(4'b0110, 3, 99, 1'b0, 1'b1);  // watchdog abort
`endif
    // randomized cases
    for (int r = 0; r < 30; r++) begin
      run(N'($urandom), int'($urandom_range(0, 5)), int'($urandom_range(0, 7)),
          ($urandom_range(0, 1) == 1), 1'b0);
    end
    @(negedge in_clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    finish_now();
  end
endmodule
